// File: rtl/cic_pkg.sv
// Shared constants, accumulator type and gain-to-shift helper for the CIC filters.
package cic_pkg;

  localparam int STAGES    = 5;
  localparam int IN_W      = 12;
  localparam int OUT_W     = 12;
  localparam int ACC_MAX_W = 64;

  // Wide enough for any legal accumulator width; narrower accumulators sign-extend into it.
  typedef logic signed [ACC_MAX_W-1:0] cic_acc_t;

  function automatic int cic_shift(input logic [7:0] gain, input int width);
    int s;
    s = width - OUT_W - int'(gain);
    return (s < 0) ? 0 : s;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One low-rate comb section (differential delay of one sample), advanced only on its valid pulse.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] comb,
  output logic             comb_vld
);

  logic [WIDTH-1:0] data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comb     <= '0;
      data_d   <= '0;
      comb_vld <= 1'b0;
    end else begin
      comb_vld <= vld;
      if (vld) begin
        comb   <= data - data_d;
        data_d <= data;
      end
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// Five-stage CIC interpolator: strobed low-rate input, zero-stuffed comb output,
// five clk-rate integrators and a power-of-two output gain.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int WIDTH               = 32,
  parameter int INTERPOLATION_RATIO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       Gain,
  input  logic [IN_W-1:0]  d_in,
  output logic             in_strobe,
  output logic [OUT_W-1:0] d_out,
  output logic             out_valid
);

  localparam int CNT_W = (INTERPOLATION_RATIO > 2) ? $clog2(INTERPOLATION_RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERPOLATION_RATIO - 1);
  localparam int VD_LEN = 4;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x;
  logic [7:0]       gain_q;
  logic             v0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      in_strobe <= 1'b0;
      x         <= '0;
      gain_q    <= '0;
      v0        <= 1'b0;
    end else begin
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      in_strobe <= (cnt == CNT_LAST);
      v0        <= in_strobe;
      if (in_strobe) begin
        x      <= {{(WIDTH-IN_W){d_in[IN_W-1]}}, d_in};
        gain_q <= Gain;
      end
    end
  end

  logic [STAGES:0][WIDTH-1:0] c;
  logic [STAGES:0]            v;

  assign c[0] = x;
  assign v[0] = v0;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
      cic_comb_stage #(
        .WIDTH(WIDTH)
      ) u_comb (
        .clk      (clk),
        .rst      (rst),
        .vld      (v[gi]),
        .data     (c[gi]),
        .comb     (c[gi+1]),
        .comb_vld (v[gi+1])
      );
    end
  endgenerate

  // Zero-stuffing: the comb result enters the integrators for exactly one clk per input sample.
  logic [WIDTH-1:0]             u;
  logic [STAGES-1:0][WIDTH-1:0] integ;
  logic [WIDTH-1:0]             i5_next;
  cic_acc_t                     i5_wide;
  int                           sh;

  assign u       = v[STAGES] ? c[STAGES] : '0;
  assign i5_next = integ[STAGES-1] + integ[STAGES-2];
  assign i5_wide = cic_acc_t'($signed(i5_next));
  assign sh      = cic_shift(gain_q, WIDTH);

  logic [VD_LEN-1:0] vd;

  // d_out is taken from the value the last integrator is loading this edge, so it
  // tracks i5 with no extra register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ     <= '0;
      vd        <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      integ[0] <= integ[0] + u;
      for (int k = 1; k < STAGES; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
      vd        <= {vd[VD_LEN-2:0], v[STAGES]};
      out_valid <= out_valid | vd[VD_LEN-1];
      d_out     <= OUT_W'(i5_wide >>> sh);
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Checks three interpolator configurations against a convolution model of the
// five cascaded boxcars applied to the zero-stuffed input.
module tb_cic_interpolator;

  localparam int NCH = 3;
  localparam int W0 = 32, R0 = 16;
  localparam int W1 = 28, R1 = 16;
  localparam int W2 = 32, R2 = 2;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] gain = 8'd0;
  logic [11:0] d_in = 12'd0;
  logic [NCH-1:0] strobe;
  logic [NCH-1:0][11:0] dout;
  logic [NCH-1:0] oval;

  always #5 clk = ~clk;

  cic_interpolator #(.WIDTH(W0), .INTERPOLATION_RATIO(R0)) dut0 (
    .clk(clk), .rst(rst), .Gain(gain), .d_in(d_in),
    .in_strobe(strobe[0]), .d_out(dout[0]), .out_valid(oval[0]));
  cic_interpolator #(.WIDTH(W1), .INTERPOLATION_RATIO(R1)) dut1 (
    .clk(clk), .rst(rst), .Gain(gain), .d_in(d_in),
    .in_strobe(strobe[1]), .d_out(dout[1]), .out_valid(oval[1]));
  cic_interpolator #(.WIDTH(W2), .INTERPOLATION_RATIO(R2)) dut2 (
    .clk(clk), .rst(rst), .Gain(gain), .d_in(d_in),
    .in_strobe(strobe[2]), .d_out(dout[2]), .out_valid(oval[2]));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int w_of(input int ch);
    case (ch)
      1:       return W1;
      2:       return W2;
      default: return W0;
    endcase
  endfunction

  function automatic int r_of(input int ch);
    case (ch)
      1:       return R1;
      2:       return R2;
      default: return R0;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint h [NCH][0:127];
  int     hlen [NCH];
  longint ka [0:127];
  longint kb [0:127];

  longint      xu [NCH][0:255];
  int          n_edge [NCH];
  int          first_cap [NCH];
  logic [7:0]  g_eff [NCH];
  logic [11:0] exp_dout [NCH];
  logic        exp_val [NCH];
  logic        exp_stb [NCH];

  task automatic build_kernels();
    int len, r;
    for (int ch = 0; ch < NCH; ch++) begin
      r = r_of(ch);
      for (int i = 0; i < 128; i++) ka[i] = 0;
      ka[0] = 1;
      len = 1;
      repeat (5) begin
        for (int j = 0; j < len + r - 1; j++) begin
          kb[j] = 0;
          for (int t = 0; t < r; t++)
            if (j - t >= 0 && j - t < len) kb[j] += ka[j-t];
        end
        len = len + r - 1;
        for (int j = 0; j < len; j++) ka[j] = kb[j];
      end
      for (int j = 0; j < 128; j++) h[ch][j] = (j < len) ? ka[j] : 0;
      hlen[ch] = len;
    end
  endtask

  function automatic logic [11:0] scale(input longint acc, input int w, input logic [7:0] g);
    longint m, v;
    int s;
    m = longint'(1) << w;
    v = acc % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    s = w - 12 - int'(g);
    if (s < 0) s = 0;
    v = v >>> s;
    return v[11:0];
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int i = 0; i < 256; i++) xu[ch][i] = 0;
      n_edge[ch]    = 0;
      first_cap[ch] = -1;
      g_eff[ch]     = 8'd0;
      exp_dout[ch]  = 12'd0;
      exp_val[ch]   = 1'b0;
      exp_stb[ch]   = 1'b0;
    end
  endtask

  task automatic model_step();
    int n, r;
    bit cap;
    longint acc;
    for (int ch = 0; ch < NCH; ch++) begin
      r = r_of(ch);
      n = n_edge[ch] + 1;
      n_edge[ch] = n;
      cap = (n - 1 > 0) && ((n - 1) % r == 0);
      xu[ch][n % 256] = cap ? longint'($signed(d_in)) : 64'sd0;
      if (cap && first_cap[ch] < 0) first_cap[ch] = n;
      acc = 0;
      for (int k = 0; k < hlen[ch]; k++)
        if (n - LAT - k >= 1) acc += h[ch][k] * xu[ch][(n - LAT - k) % 256];
      exp_dout[ch] = scale(acc, w_of(ch), g_eff[ch]);
      exp_val[ch]  = (first_cap[ch] >= 0) && (n >= first_cap[ch] + LAT);
      exp_stb[ch]  = (n % r == 0);
      if (cap) g_eff[ch] = gain;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
        check($sformatf("ch%0d d_out", ch), longint'(dout[ch]), longint'(exp_dout[ch]));
        check($sformatf("ch%0d out_valid", ch), longint'(oval[ch]), longint'(exp_val[ch]));
        check($sformatf("ch%0d in_strobe", ch), longint'(strobe[ch]), longint'(exp_stb[ch]));
      end
    end
  end

  // ---------------- stimulus ----------------
  int binom [6] = '{1, 5, 15, 35, 70, 126};
  logic [7:0] gain_pick [8] = '{8'd0, 8'd2, 8'd4, 8'd5, 8'd8, 8'd16, 8'd20, 8'd255};

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_strobe0();
    int k;
    k = 0;
    while (strobe[0] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("strobe0_wait", longint'(strobe[0]), 64'd1);
  endtask

  initial begin
    longint hsum;
    build_kernels();
    model_clear();

    hsum = 0;
    for (int k = 0; k < hlen[0]; k++) hsum += h[0][k];
    check("model_kernel_sum", hsum, 64'd1048576);
    check("model_kernel_tap5", h[0][5], 64'd126);
    check("model_kernel_len", longint'(hlen[0]), 64'd76);

    $display("phase: reset state and strobe cadence");
    tick(3);
    check("reset d_out", longint'(dout[0]), 64'd0);
    check("reset out_valid", longint'(oval[0]), 64'd0);
    check("reset in_strobe", longint'(strobe[0]), 64'd0);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check("cadence in_strobe", longint'(strobe[0]), longint'(c % 16 == 0));
      check("cadence out_valid", longint'(oval[0]), longint'(c >= 27));
      check("cadence d_out", longint'(dout[0]), 64'd0);
    end

    $display("phase: impulse at Gain=20");
    do_reset();
    gain = 8'd20;
    d_in = 12'd0;
    wait_strobe0();
    d_in = 12'd1;
    for (int e = 0; e < LAT; e++) begin
      @(negedge clk);
      if (e == 0) d_in = 12'd0;
      check("impulse pre d_out", longint'(dout[0]), 64'd0);
      check("impulse pre out_valid", longint'(oval[0]), 64'd0);
    end
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      check("impulse tap", longint'(dout[0]), longint'(binom[m]));
    end
    check("impulse out_valid", longint'(oval[0]), 64'd1);
    tick(80);

    $display("phase: DC step +100 and -2048 at Gain=4");
    do_reset();
    gain = 8'd4;
    d_in = 12'd100;
    tick(120);
    for (int i = 0; i < 20; i++) begin
      check("dc +100", longint'(dout[0]), 64'd100);
      @(negedge clk);
    end
    d_in = 12'h800;
    tick(110);
    for (int i = 0; i < 20; i++) begin
      check("dc -2048", longint'(dout[0]), longint'(12'h800));
      @(negedge clk);
    end

    $display("phase: gain change 4 -> 5 between strobes");
    d_in = 12'd100;
    tick(110);
    if (strobe[0] === 1'b1) tick(1);
    check("gain pre d_out", longint'(dout[0]), 64'd100);
    gain = 8'd5;
    tick(1);
    wait_strobe0();
    tick(1);
    check("gain capture-edge d_out", longint'(dout[0]), 64'd100);
    tick(1);
    check("gain next-edge d_out", longint'(dout[0]), 64'd200);
    tick(20);
    check("gain settled d_out", longint'(dout[0]), 64'd200);

    $display("phase: ramp with mid-run reset");
    do_reset();
    gain = 8'd4;
    d_in = 12'd0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      d_in = d_in + 12'd1;
    end
    #2 rst = 1'b1;
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("midrst ch%0d d_out", ch), longint'(dout[ch]), 64'd0);
      check($sformatf("midrst ch%0d out_valid", ch), longint'(oval[ch]), 64'd0);
      check($sformatf("midrst ch%0d in_strobe", ch), longint'(strobe[ch]), 64'd0);
    end
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      d_in = d_in + 12'd1;
    end

    $display("phase: random samples and gains");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d_in = 12'($urandom);
      if ($urandom_range(0, 49) == 0) gain = gain_pick[$urandom_range(0, 7)];
    end

    $display("phase: integrator wrap, full-scale DC at Gain=0");
    do_reset();
    gain = 8'd0;
    d_in = 12'd2047;
    tick(1000 * R0);
    check("wrap ch1 +2047", longint'(dout[1]), 64'd2047);
    check("wrap ch0 +2047", longint'(dout[0]), 64'd127);
    d_in = 12'h800;
    tick(200 * R0);
    check("wrap ch1 -2048", longint'(dout[1]), longint'(12'h800));
    check("wrap ch0 -2048", longint'(dout[0]), longint'(12'hF80));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
